// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the CPU memory responder: I/O register offsets,
// STATUS bit positions and the decoded-target type.
package mem_map_pkg;

  localparam logic [31:0] OFS_LED    = 32'h0000_0000;
  localparam logic [31:0] OFS_SW     = 32'h0000_0004;
  localparam logic [31:0] OFS_CYCLE  = 32'h0000_0008;
  localparam logic [31:0] OFS_TXDATA = 32'h0000_000C;
  localparam logic [31:0] OFS_STATUS = 32'h0000_0010;

  localparam int unsigned STAT_EMPTY = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_ERR   = 2;

  typedef enum logic [2:0] {
    SelNone,
    SelRam,
    SelLed,
    SelSw,
    SelCycle,
    SelTx,
    SelStatus
  } sel_e;

endpackage

// File: rtl/tx_fifo.sv
// Small synchronous byte FIFO with registered occupancy; head is presented without
// fall-through, and a push into a full FIFO is only accepted alongside a pop.
module tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk0,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] CntFull = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntFull);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk0) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Storage is not reset, so mask the head while empty to keep the output clean.
  assign dout = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_responder.sv
// Responder for the CPU memory bus: word RAM plus an I/O block (LED, synchronised
// switches, cycle counter, TX byte FIFO, STATUS), all with one-cycle registered reads.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LED_W      = 8,
  parameter int unsigned SW_W       = 8
) (
  input  logic             clk0,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      din,
  input  logic             wren,
  output logic [31:0]      dout,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  sw,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             err
);

  localparam int unsigned AW = $clog2(DEPTH);

  sel_e             sel;
  logic [AW-1:0]    ram_idx;
  logic [31:0]      ram_q [DEPTH];
  logic [31:0]      rd_data, status;
  logic [31:0]      dout_q, cycle_q, cycle_d;
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
  logic             err_q, err_d;
  logic             fifo_full, fifo_empty, tx_push, tx_pop;

  assign ram_idx = addr[AW+1:2];

  always_comb begin
    sel = SelNone;
    if (addr[1:0] == 2'b00) begin
      if (addr[31:AW+2] == '0)                 sel = SelRam;
      else if (addr == MMIO_BASE + OFS_LED)    sel = SelLed;
      else if (addr == MMIO_BASE + OFS_SW)     sel = SelSw;
      else if (addr == MMIO_BASE + OFS_CYCLE)  sel = SelCycle;
      else if (addr == MMIO_BASE + OFS_TXDATA) sel = SelTx;
      else if (addr == MMIO_BASE + OFS_STATUS) sel = SelStatus;
    end
  end

  assign tx_push  = wren & (sel == SelTx);
  assign tx_valid = ~fifo_empty;
  assign tx_pop   = tx_valid & tx_ready;

  always_comb begin
    status             = '0;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_FULL]  = fifo_full;
    status[STAT_ERR]   = err_q;
  end

  always_comb begin
    rd_data = '0;
    unique case (sel)
      SelRam:    rd_data = ram_q[ram_idx];
      SelLed:    rd_data = 32'(led_q);
      SelSw:     rd_data = 32'(sw_sync_q);
      SelCycle:  rd_data = cycle_q;
      SelStatus: rd_data = status;
      default:   rd_data = '0;
    endcase
  end

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (wren && sel == SelCycle) cycle_d = '0;
  end

  // Setting takes priority over a STATUS write-clear in the same cycle.
  always_comb begin
    err_d = err_q;
    if (wren && sel == SelStatus && din[STAT_ERR]) err_d = 1'b0;
    if (sel == SelNone || (tx_push && fifo_full && !tx_pop)) err_d = 1'b1;
  end

  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      dout_q    <= '0;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cycle_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      dout_q    <= rd_data;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      cycle_q   <= cycle_d;
      err_q     <= err_d;
      if (wren && sel == SelLed) led_q <= din[LED_W-1:0];
    end
  end

  always_ff @(posedge clk0) begin
    if (wren && sel == SelRam) ram_q[ram_idx] <= din;
  end

  tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_tx_fifo (
    .clk0 (clk0),
    .rst  (rst),
    .push (tx_push),
    .din  (din[7:0]),
    .full (fifo_full),
    .pop  (tx_pop),
    .dout (tx_data),
    .empty(fifo_empty)
  );

  assign dout = dout_q;
  assign led  = led_q;
  assign err  = err_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the CPU memory interface (addr/din/wren/dout).
- Replaces the bare BRAM with a decoded target: a word RAM region plus a small memory-mapped I/O region.
- The I/O region holds an LED register, synchronised switch inputs, a free-running cycle counter, and a byte TX FIFO drained by a downstream consumer over a valid/ready handshake.
- Keeps the BRAM timing contract: synchronous read, one-cycle latency, on clk0.

Parameters:
- DEPTH, 1024, RAM size in 32-bit words (power of 2).
- MMIO_BASE, 32'hFFFF_0000, base byte address of the I/O region.
- FIFO_DEPTH, 4, TX FIFO entries (power of 2, >=2).
- LED_W, 8, LED register width.
- SW_W, 8, switch input width.

Ports:
- clk0  in  1  system clock; all state on posedge.
- rst  in  1  reset, asynchronous, active-low.
- addr  in  32  byte address from CPU.
- din  in  32  write data from CPU.
- wren  in  1  write enable, sampled at posedge clk0.
- dout  out  32  registered read data.
- led  out  LED_W  LED register value.
- sw  in  SW_W  asynchronous switch inputs.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  consumer accepts head this cycle.
- err  out  1  sticky access-error flag.

Behaviour:
- Reset: rst low asynchronously clears dout=0, led=0, counter=0, FIFO empty (tx_valid=0, tx_data=0), err=0, switch synchroniser=0. RAM contents are not reset.
- Address map (word aligned):
  - RAM: 0 .. DEPTH*4-1; word index addr[log2(DEPTH)+1:2].
  - MMIO_BASE+0x00 LED: RW, low LED_W bits; reads zero-extended.
  - +0x04 SW: RO; returns the 2-flop-synchronised sw.
  - +0x08 CYCLE: RO count; any write clears it.
  - +0x0C TXDATA: WO; write pushes din[7:0]; reads return 0.
  - +0x10 STATUS: bit0 fifo_empty, bit1 fifo_full, bit2 err, others 0. Writing din[2]=1 clears err; other bits are ignored.
- Read latency: dout at edge N+1 reflects the address sampled at edge N. A RAM read with a same-address write in the same cycle returns old data (read-before-write). Every MMIO read reflects the pre-edge register value.
- Errors: addr[1:0]!=0 or an unmapped address sets err. The write is dropped and the next dout is 0.
- CYCLE: increments by 1 every clk0 and wraps 32'hFFFFFFFF->0. A write-clear in the same cycle wins, giving 0 after the edge.
- TX FIFO:
  - Push on wren & addr==TXDATA. Pop on tx_valid & tx_ready.
  - No fall-through: after a push into an empty FIFO, tx_valid rises at the next edge.
  - tx_data is the head entry, stable while tx_valid=1 and tx_ready=0.
  - Push while full and no pop: data dropped, err set.
  - Push and pop in the same cycle when full: both happen, count unchanged, no error.
  - Push and pop in the same cycle when non-empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy uses a log2(FIFO_DEPTH)+1-bit count.
- err: if set and clear occur in the same cycle, set wins.
- Reset mid-operation: FIFO contents are discarded and tx_valid drops immediately (async).

Decomposition:
- Package mem_map_pkg: MMIO offset constants (OFS_LED, OFS_SW, OFS_CYCLE, OFS_TXDATA, OFS_STATUS) and STATUS bit indices.
- Sub-module tx_fifo (DEPTH, WIDTH params; push/din/full, pop/dout/empty, clk0, rst).
- Address decode, RAM, counter and registers stay in mem_responder.

Test Plan:
- RAM write/read: write 0xDEADBEEF at 0x10, then read 0x10 -> dout=0xDEADBEEF one edge after the read address. Simultaneous write 0x1 to 0x10 with read 0x10 -> old value 0xDEADBEEF.
- LED/SW: write 0x1A5 to MMIO_BASE -> led=0xA5; read -> dout=0xA5. Drive sw=0x3C -> SW read returns 0x3C no earlier than 2 edges after the change.
- Counter: release reset, read CYCLE after 10 edges -> expected count (±latency, checked exactly). Force 0xFFFFFFFF via clear+wait model -> wraps to 0. Write at the same edge as an increment -> 0.
- FIFO:
  - Push 0x11,0x22,0x33,0x44 with tx_ready=0 -> STATUS=0x2; fifth push 0x55 dropped, err=1, STATUS=0x6.
  - Set tx_ready=1 -> tx_data 0x11,0x22,0x33,0x44 on consecutive edges, then tx_valid=0, STATUS bit0=1.
- Full push+pop: fill 4, push 0x66 with tx_ready=1 -> no err, head advances, 0x66 emerges last.
- Errors: read 0x2 -> dout=0, err=1; write STATUS din=0x4 -> err=0. Write to 0x8000_0000 -> RAM unchanged, err=1. Assert rst low mid-drain -> tx_valid=0 and dout=0 without a clock edge.
